// File: rtl/cfg_frame_decoder_pkg.sv
// Shared types and constants for the configuration frame decoder.
package cfg_frame_decoder_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA_HI,
        S_DATA_LO,
        S_CHECK,
        S_ISSUE
    } state_t;

    localparam logic [3:0] ERR_NONE = 4'h0;
    localparam logic [3:0] ERR_HDR  = 4'h1;
    localparam logic [3:0] ERR_HI   = 4'h2;
    localparam logic [3:0] ERR_CHK  = 4'h3;
    localparam logic [3:0] ERR_TMO  = 4'h4;
    localparam logic [3:0] ERR_OVR  = 4'h5;

    localparam logic [3:0] SYNC_NIBBLE_DEF = 4'hA;

    function automatic logic is_timed(state_t s);
        return (s == S_DATA_HI) || (s == S_DATA_LO) || (s == S_CHECK);
    endfunction

endpackage

// File: rtl/cfg_frame_decoder_gap.sv
// Inter-byte gap timer: pulses expired on the cycle the idle count
// reaches TIMEOUT_CYCLES-1 while still counting.
module gap_timer #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt;

    assign expired = en & ~clr & (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || expired) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cfg_frame_decoder.sv
// Turns 4-byte UART frames (header, data-hi, data-lo, checksum) into
// configuration-bus requests and reports framing faults.
module cfg_frame_decoder
    import cfg_frame_decoder_pkg::*;
#(
    parameter logic [3:0] SYNC_NIBBLE    = SYNC_NIBBLE_DEF,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        c_valid,
    output logic [3:0]  c_addr,
    output logic [13:0] c_data,
    input  logic        c_ready,
    output logic        done,
    output logic [3:0]  err_code,
    output logic        err_valid
);

    state_t      state;
    logic [3:0]  addr_q;
    logic [13:0] data_q;
    logic [7:0]  chk;
    logic        timed;
    logic        expired;

    assign timed = is_timed(state);

    // A byte always beats a same-cycle expiry, so it also clears the count.
    gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (rx_valid | ~timed),
        .en     (timed & ~rx_valid),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            chk       <= '0;
            c_valid   <= 1'b0;
            c_addr    <= '0;
            c_data    <= '0;
            done      <= 1'b0;
            err_valid <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            done      <= 1'b0;
            err_valid <= 1'b0;
            err_code  <= ERR_NONE;
            unique case (state)
                S_IDLE: begin
                    if (rx_valid) begin
                        if (rx_data[7:4] == SYNC_NIBBLE) begin
                            addr_q <= rx_data[3:0];
                            chk    <= rx_data;
                            state  <= S_DATA_HI;
                        end else begin
                            err_valid <= 1'b1;
                            err_code  <= ERR_HDR;
                        end
                    end
                end
                S_DATA_HI: begin
                    if (rx_valid) begin
                        if (rx_data[7:6] == 2'b00) begin
                            data_q[13:8] <= rx_data[5:0];
                            chk          <= chk ^ rx_data;
                            state        <= S_DATA_LO;
                        end else begin
                            err_valid <= 1'b1;
                            err_code  <= ERR_HI;
                            state     <= S_IDLE;
                        end
                    end else if (expired) begin
                        err_valid <= 1'b1;
                        err_code  <= ERR_TMO;
                        state     <= S_IDLE;
                    end
                end
                S_DATA_LO: begin
                    if (rx_valid) begin
                        data_q[7:0] <= rx_data;
                        chk         <= chk ^ rx_data;
                        state       <= S_CHECK;
                    end else if (expired) begin
                        err_valid <= 1'b1;
                        err_code  <= ERR_TMO;
                        state     <= S_IDLE;
                    end
                end
                S_CHECK: begin
                    if (rx_valid) begin
                        if (rx_data == chk) begin
                            c_valid <= 1'b1;
                            c_addr  <= addr_q;
                            c_data  <= data_q;
                            state   <= S_ISSUE;
                        end else begin
                            err_valid <= 1'b1;
                            err_code  <= ERR_CHK;
                            state     <= S_IDLE;
                        end
                    end else if (expired) begin
                        err_valid <= 1'b1;
                        err_code  <= ERR_TMO;
                        state     <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    if (rx_valid) begin
                        err_valid <= 1'b1;
                        err_code  <= ERR_OVR;
                    end
                    if (c_ready) begin
                        c_valid <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_frame_decoder.sv
// Directed and randomized checks of cfg_frame_decoder against a
// frame-buffer reference model.
module tb_cfg_frame_decoder;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        c_ready = 1'b0;
    logic        c_valid;
    logic [3:0]  c_addr;
    logic [13:0] c_data;
    logic        done;
    logic [3:0]  err_code;
    logic        err_valid;

    int errors = 0;
    int checks = 0;

    logic [7:0]  fr[$];
    bit          issuing;
    logic [3:0]  m_addr;
    logic [13:0] m_data;
    bit          m_done;
    bit          m_ev;
    logic [3:0]  m_code;
    int          gap;

    cfg_frame_decoder #(
        .SYNC_NIBBLE   (4'hA),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .c_valid  (c_valid),
        .c_addr   (c_addr),
        .c_data   (c_data),
        .c_ready  (c_ready),
        .done     (done),
        .err_code (err_code),
        .err_valid(err_valid)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        fr.delete();
        issuing = 0;
        m_addr  = '0;
        m_data  = '0;
        m_done  = 0;
        m_ev    = 0;
        m_code  = '0;
        gap     = 0;
    endtask

    task automatic raise(logic [3:0] code);
        m_ev   = 1;
        m_code = code;
    endtask

    // Expected outcome of one clock edge, from the frame rules.
    task automatic model(bit v, logic [7:0] d, bit rdy);
        logic [7:0] x;
        m_done = 0;
        m_ev   = 0;
        m_code = '0;
        if (issuing) begin
            if (v) raise(4'h5);
            if (rdy) begin
                issuing = 0;
                m_done  = 1;
            end
        end else if (v) begin
            fr.push_back(d);
            gap = 0;
            case (fr.size())
                1: if (d[7:4] != 4'hA) begin raise(4'h1); fr.delete(); end
                2: if (d[7:6] != 2'b00) begin raise(4'h2); fr.delete(); end
                4: begin
                    x = fr[0] ^ fr[1] ^ fr[2];
                    if (d == x) begin
                        issuing = 1;
                        m_addr  = fr[0][3:0];
                        m_data  = {fr[1][5:0], fr[2]};
                    end else begin
                        raise(4'h3);
                    end
                    fr.delete();
                end
                default: ;
            endcase
        end else if (fr.size() != 0) begin
            gap++;
            if (gap == T) begin
                raise(4'h4);
                fr.delete();
                gap = 0;
            end
        end
    endtask

    task automatic compare();
        check("c_valid", 16'(c_valid), 16'(issuing));
        check("c_addr", 16'(c_addr), 16'(m_addr));
        check("c_data", 16'(c_data), 16'(m_data));
        check("done", 16'(done), 16'(m_done));
        check("err_valid", 16'(err_valid), 16'(m_ev));
        check("err_code", 16'(err_code), 16'(m_code));
    endtask

    task automatic step(bit v, logic [7:0] d, bit rdy);
        rx_valid = v;
        rx_data  = d;
        c_ready  = rdy;
        @(posedge clk);
        model(v, d, rdy);
        #1;
        compare();
        rx_valid = 1'b0;
    endtask

    task automatic idle(int n, bit rdy);
        for (int i = 0; i < n; i++) step(0, 8'h00, rdy);
    endtask

    task automatic frame(logic [7:0] a, logic [7:0] b, logic [7:0] c,
                         logic [7:0] k, bit rdy);
        step(1, a, rdy);
        step(1, b, rdy);
        step(1, c, rdy);
        step(1, k, rdy);
    endtask

    task automatic reset_dut(int cycles);
        rst_n = 1'b0;
        model_reset();
        #1;
        compare();
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1'b1;
        compare();
    endtask

    initial begin
        logic [7:0] h;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] k;
        int kind;
        model_reset();
        @(posedge clk);
        #1;
        reset_dut(2);

        // good frame, ready high
        frame(8'hA3, 8'h2B, 8'h7C, 8'hF4, 1'b1);
        check("good_valid", 16'(c_valid), 16'h1);
        check("good_addr", 16'(c_addr), 16'h3);
        check("good_data", 16'(c_data), 16'h2B7C);
        step(0, 8'h00, 1'b1);
        check("good_done", 16'(done), 16'h1);
        check("good_noerr", 16'(err_valid), 16'h0);

        // stalled ready with overrun byte
        frame(8'hA3, 8'h2B, 8'h7C, 8'hF4, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(i == 9, 8'h55, 1'b0);
            if (i == 9) check("ovr_code", 16'(err_code), 16'h5);
            check("stall_data", 16'(c_data), 16'h2B7C);
        end
        step(0, 8'h00, 1'b1);
        check("stall_done", 16'(done), 16'h1);

        // overrun on the handshake cycle, then header while done is high
        frame(8'hA5, 8'h01, 8'h02, 8'hA6, 1'b0);
        step(1, 8'h55, 1'b1);
        check("ovr_hs_code", 16'(err_code), 16'h5);
        check("ovr_hs_done", 16'(done), 16'h1);
        step(1, 8'hA7, 1'b1);
        step(1, 8'h3F, 1'b1);
        step(1, 8'hFF, 1'b1);
        step(1, 8'hA7 ^ 8'h3F ^ 8'hFF, 1'b1);
        check("b2b_data", 16'(c_data), 16'h3FFF);
        idle(2, 1'b1);

        // bad header, then good frame
        step(1, 8'h53, 1'b1);
        check("hdr_code", 16'(err_code), 16'h1);
        frame(8'hA3, 8'h2B, 8'h7C, 8'hF4, 1'b1);
        idle(2, 1'b1);

        // bad data-high and bad checksum
        step(1, 8'hA3, 1'b1);
        step(1, 8'h40, 1'b1);
        check("hi_code", 16'(err_code), 16'h2);
        frame(8'hA3, 8'h2B, 8'h7C, 8'hF5, 1'b1);
        check("chk_code", 16'(err_code), 16'h3);
        check("chk_novalid", 16'(c_valid), 16'h0);
        idle(2, 1'b1);

        // timeout after exactly T idle cycles
        step(1, 8'hA3, 1'b1);
        idle(T, 1'b1);
        check("tmo_code", 16'(err_code), 16'h4);
        idle(T + 3, 1'b1);
        // byte on the expiry cycle wins
        step(1, 8'hA3, 1'b1);
        idle(T - 1, 1'b1);
        step(1, 8'h2B, 1'b1);
        check("tmo_suppr", 16'(err_valid), 16'h0);
        step(1, 8'h7C, 1'b1);
        step(1, 8'hF4, 1'b1);
        check("tmo_suppr_valid", 16'(c_valid), 16'h1);
        idle(2, 1'b1);

        // reset mid-frame
        step(1, 8'hA3, 1'b1);
        step(1, 8'h2B, 1'b1);
        reset_dut(1);
        frame(8'hA9, 8'h12, 8'h34, 8'hA9 ^ 8'h12 ^ 8'h34, 1'b1);
        check("rst_addr", 16'(c_addr), 16'h9);
        idle(2, 1'b1);

        // reset mid-issue
        frame(8'hA1, 8'h01, 8'h01, 8'hA1, 1'b0);
        reset_dut(1);
        idle(2, 1'b1);

        // randomized frames
        for (int f = 0; f < 300; f++) begin
            kind = $urandom_range(0, 9);
            h  = {(kind < 8) ? 4'hA : 4'($urandom), 4'($urandom)};
            b1 = (kind == 7) ? 8'($urandom) : {2'b00, 6'($urandom)};
            b2 = 8'($urandom);
            k  = (kind == 6) ? 8'($urandom) : (h ^ b1 ^ b2);
            for (int j = 0; j < 4; j++) begin
                if ($urandom_range(0, 19) == 0)
                    idle($urandom_range(T - 2, T + 1), 1'($urandom));
                else
                    idle($urandom_range(0, 3), 1'($urandom));
                step(1, (j == 0) ? h : (j == 1) ? b1 : (j == 2) ? b2 : k,
                     1'($urandom));
            end
        end
        idle(T + 4, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cfg_frame_decoder.md
# cfg_frame_decoder

Assembles the byte stream from the UART receive path into configuration-bus transactions. It sits between the UART-to-CM synchronising FIFO and the configuration master. It validates 4-byte frames (header, data-high, data-low, checksum) and drives the shared `c_valid`/`c_addr`/`c_data`/`c_ready` handshake. Framing faults are reported as 4-bit codes on the notification path that feeds the LED manager.

## Interface
- `SYNC_NIBBLE`, default 4'hA: required upper nibble of the header byte.
- `TIMEOUT_CYCLES`, default 100000: maximum idle cycles allowed between bytes inside a frame.
- `clk`  in  1  single clock; every register is in this domain.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` holds a byte.
- `rx_data`  in  8  received byte.
- `c_valid`  out  1  configuration request.
- `c_addr`  out  4  configuration address.
- `c_data`  out  14  configuration data.
- `c_ready`  in  1  AND of all configuration-bus slave readies.
- `done`  out  1  one-cycle pulse when a transaction completes.
- `err_code`  out  4  fault code; valid only while `err_valid` is high.
- `err_valid`  out  1  one-cycle fault strobe.

## Operation
- States: IDLE, DATA_HI, DATA_LO, CHECK, ISSUE.
- IDLE, on a byte:
  - if byte[7:4]==SYNC_NIBBLE: latch addr=byte[3:0], chk=byte, go to DATA_HI;
  - otherwise: err 4'h1 (bad header), stay in IDLE.
- DATA_HI, on a byte:
  - if byte[7:6]==2'b00: latch data[13:8], XOR the byte into chk, go to DATA_LO;
  - otherwise: err 4'h2, go to IDLE.
- DATA_LO, on a byte: latch data[7:0], XOR into chk, go to CHECK.
- CHECK, on a byte:
  - if byte==chk: go to ISSUE;
  - otherwise: err 4'h3, go to IDLE.
- ISSUE: `c_valid`=1 with `c_addr`/`c_data` held stable. On `c_valid & c_ready`: pulse `done`, go to IDLE.
- Timeout (DATA_HI, DATA_LO, CHECK only): the gap counter clears on every accepted byte and on entry to these states. When it reaches TIMEOUT_CYCLES-1 with no byte: err 4'h4, go to IDLE. ISSUE never times out.
- Overrun: a byte arriving in ISSUE is dropped, err 4'h5, state unchanged.
- Error codes are otherwise 4'h0. No error aborts ISSUE.

## Timing
- Reset values: state IDLE, `c_valid`=0, `c_addr`=0, `c_data`=0, `done`=0, `err_valid`=0, `err_code`=0, gap counter 0, chk 0.
- All outputs are registered.
- `c_valid` rises on the cycle after the clock edge that samples a correct checksum byte. Latency from the checksum strobe to `c_valid` is 1 cycle.
- `c_valid` falls, and `done` pulses, on the cycle after the handshake cycle.
- A back-to-back header byte arriving on the same cycle `done` is high is accepted normally from IDLE.
- `err_valid` pulses on the cycle after the offending byte, or after the timeout expiry cycle.
- Simultaneous events:
  - byte strobe and timeout expiry in the same cycle: the byte wins, no timeout.
  - byte in ISSUE on the handshake cycle: the byte is still dropped. Err 4'h5 and `done` pulse together.
- `rst_n` asserted mid-frame or mid-ISSUE: immediate return to reset values. The partial frame is discarded with no error reported.
- `c_addr`/`c_data` hold their last value after the handshake.

## Structure
- Shared params include:
  - state encoding;
  - error codes ERR_HDR=1, ERR_HI=2, ERR_CHK=3, ERR_TMO=4, ERR_OVR=5;
  - SYNC_NIBBLE default.
- Sub-module `gap_timer` (parameter TIMEOUT_CYCLES): inputs `clr` and `en`, output `expired` (one-cycle pulse). Width is $clog2(TIMEOUT_CYCLES).
- FSM, frame registers and checksum are in the top module.

## Test plan
- Good frame, with c_ready held high:
  - stimulus: A3, 2B, 7C, F4;
  - response: one c_valid cycle with c_addr=4'h3, c_data=14'h2B7C, then a done pulse and no err_valid.
- Stalled ready, same frame with c_ready low for 20 cycles:
  - c_valid and the data stay stable for 20 cycles;
  - raising c_ready gives one handshake, then done;
  - a byte 55 sent during the stall gives err 4'h5, and the transaction still completes.
- Bad header: byte 53 -> err 4'h1, state IDLE; a following good frame decodes correctly.
- Bad fields:
  - A3, 40 -> err 4'h2;
  - A3, 2B, 7C, F5 -> err 4'h3 and no c_valid.
- Timeout, with TIMEOUT_CYCLES=16:
  - A3 then 16 idle cycles -> err 4'h4 once;
  - a byte on exactly the expiry cycle suppresses the timeout.
- Reset mid-frame: A3, 2B, then rst_n low for 1 cycle -> all outputs at reset values; a new full frame decodes correctly.
